cc_expun_queue: RTL and testbench

- Buffers victim line addresses expunged by the eight L1 tag ways and drains them one per handshake to the writeback/snoop agent.
- Sits directly downstream of the per-way tag arrays; each way supplies its expunge-enable and expunge-address outputs.
- Exposes an almost-full throttle back to the tag write path.
- Provides a 1-cycle CAM lookup so a refill or snoop can detect a pending eviction of the same line.

---
 rtl/cc_expun_queue_pkg.sv | 15 +
 rtl/cc_expun_queue_if.sv | 37 +++
 rtl/cc_expun_cam.sv | 23 ++
 rtl/cc_expun_queue.sv | 128 ++++++++++++
 tb/tb_cc_expun_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cc_expun_queue_pkg.sv
// Shared expunge-path types: line-address width and the queue entry layout.
// The same definitions are used by the tag-array expunge outputs.
package cc_expun_queue_pkg;

  localparam int unsigned cc1_phys_bits      = 44;
  localparam int unsigned cc1_lineaddr_width = cc1_phys_bits - 7;

  typedef logic [cc1_lineaddr_width-1:0] line_addr_t;

  typedef struct packed {
    logic       valid;
    line_addr_t addr;
  } exp_entry_t;

endpackage

// File: rtl/cc_expun_queue_if.sv
// Expunge queue bus: tag-way expunge inputs, drain handshake, CAM probe,
// throttle and status.
//   master: tag side / consumer (drives exp_*, flush, out_ready, lookup_*)
//   slave : the queue (drives out_*, lookup_hit, almost_full, count, err_*)
interface cc_expun_queue_if #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned DEPTH = 8
);
  import cc_expun_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WAYS-1:0]              exp_en;
  logic [WAYS-1:0][cc1_lineaddr_width-1:0] exp_addr;
  logic                         flush;
  logic                         out_valid;
  line_addr_t                   out_addr;
  logic                         out_ready;
  logic                         lookup_en;
  line_addr_t                   lookup_addr;
  logic                         lookup_hit;
  logic                         almost_full;
  logic [CNT_W-1:0]             count;
  logic                         err_multi;
  logic                         err_ovf;

  modport master (
    output exp_en, exp_addr, flush, out_ready, lookup_en, lookup_addr,
    input  out_valid, out_addr, lookup_hit, almost_full, count, err_multi, err_ovf
  );

  modport slave (
    input  exp_en, exp_addr, flush, out_ready, lookup_en, lookup_addr,
    output out_valid, out_addr, lookup_hit, almost_full, count, err_multi, err_ovf
  );

endinterface

// File: rtl/cc_expun_cam.sv
// Address CAM over the queue entries: one match bit per valid entry whose
// line address equals key.
//   ent     : queue entries (valid + addr)
//   key     : probe line address
//   match_c : combinational per-entry match vector
module cc_expun_cam
  import cc_expun_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  exp_entry_t [DEPTH-1:0] ent,
  input  line_addr_t             key,
  output logic [DEPTH-1:0]       match_c
);

  always_comb begin
    match_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match_c[i] = ent[i].valid && (ent[i].addr == key);
    end
  end

endmodule

// File: rtl/cc_expun_queue.sv
// Victim line-address queue between the L1 tag ways and the writeback/snoop
// agent. Dedups pushes against queued lines, throttles the tag write path via
// almost_full and answers a registered CAM probe for pending evictions.
// All flops switch on the falling clock edge, matching the tag arrays.
//   clk : clock (negedge active)
//   rst : asynchronous active-low reset
//   q   : queue bus, slave side
module cc_expun_queue
  import cc_expun_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WAYS      = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  cc_expun_queue_if.slave  q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  exp_entry_t [DEPTH-1:0] ent_q;
  logic [PTR_W-1:0]       head_q;
  logic [PTR_W-1:0]       tail_q;
  logic [CNT_W-1:0]       count_q;
  logic                   almost_full_q;
  logic                   lookup_hit_q;
  logic                   err_multi_q;
  logic                   err_ovf_q;

  line_addr_t             push_addr_c;
  logic                   push_c;
  logic                   multi_c;
  logic                   pop_c;
  logic [DEPTH-1:0]       pop_mask_c;
  logic [DEPTH-1:0]       dup_match_c;
  logic [DEPTH-1:0]       lk_match_c;
  logic                   dup_c;
  logic                   full_c;
  logic                   accept_c;
  logic                   ovf_c;
  logic [CNT_W-1:0]       next_count_c;
  logic                   af_next_c;
  logic                   hit_next_c;

  // Lowest-index active way wins; scanning downward lets it overwrite last.
  always_comb begin
    push_addr_c = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (q.exp_en[i]) push_addr_c = q.exp_addr[i];
    end
  end

  assign push_c  = |q.exp_en;
  assign multi_c = |(q.exp_en & (q.exp_en - WAYS'(1)));

  assign pop_c      = ent_q[head_q].valid & q.out_ready;
  assign pop_mask_c = pop_c ? (DEPTH'(1) << head_q) : '0;

  cc_expun_cam #(.DEPTH(DEPTH)) u_dedup_cam (
    .ent     (ent_q),
    .key     (push_addr_c),
    .match_c (dup_match_c)
  );

  cc_expun_cam #(.DEPTH(DEPTH)) u_lookup_cam (
    .ent     (ent_q),
    .key     (q.lookup_addr),
    .match_c (lk_match_c)
  );

  // The head leaving this cycle cannot absorb a new push of the same line.
  assign dup_c    = |(dup_match_c & ~pop_mask_c);
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign accept_c = push_c & ~q.flush & ~dup_c & (~full_c | pop_c);
  assign ovf_c    = push_c & ~q.flush & ~dup_c & full_c & ~pop_c;

  assign next_count_c = q.flush ? '0
                                : count_q + CNT_W'(accept_c) - CNT_W'(pop_c);
  assign af_next_c    = (CNT_W'(DEPTH) - next_count_c) <= CNT_W'(AF_MARGIN);
  assign hit_next_c   = q.lookup_en &
                        ((|lk_match_c) | (accept_c & (push_addr_c == q.lookup_addr)));

  // Queue state, throttle, probe result and sticky errors.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ent_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      lookup_hit_q  <= 1'b0;
      err_multi_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      count_q       <= next_count_c;
      almost_full_q <= af_next_c;
      lookup_hit_q  <= hit_next_c;
      if (multi_c) err_multi_q <= 1'b1;
      if (ovf_c)   err_ovf_q   <= 1'b1;
      if (q.flush) begin
        ent_q  <= '0;
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (pop_c) begin
          ent_q[head_q].valid <= 1'b0;
          head_q              <= head_q + PTR_W'(1);
        end
        // Full push+pop targets the popped slot; this write must win.
        if (accept_c) begin
          ent_q[tail_q] <= '{valid: 1'b1, addr: push_addr_c};
          tail_q        <= tail_q + PTR_W'(1);
        end
      end
    end
  end

  assign q.out_valid   = ent_q[head_q].valid;
  assign q.out_addr    = ent_q[head_q].addr;
  assign q.count       = count_q;
  assign q.almost_full = almost_full_q;
  assign q.lookup_hit  = lookup_hit_q;
  assign q.err_multi   = err_multi_q;
  assign q.err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cc_expun_queue.sv
// Self-checking bench for cc_expun_queue: a queue scoreboard holds the lines
// expected at the head and is compared on every handshake.
module tb_cc_expun_queue;
  import cc_expun_queue_pkg::*;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned WAYS      = 8;
  localparam int unsigned AF_MARGIN = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  line_addr_t sb[$];
  bit         m_multi;
  bit         m_ovf;
  bit         m_af;
  bit         m_hit;

  cc_expun_queue_if #(.WAYS(WAYS), .DEPTH(DEPTH)) bus ();

  cc_expun_queue #(.DEPTH(DEPTH), .WAYS(WAYS), .AF_MARGIN(AF_MARGIN)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic set_push(input int way, input line_addr_t a);
    bus.exp_en        = '0;
    bus.exp_addr      = '0;
    bus.exp_en[way]   = 1'b1;
    bus.exp_addr[way] = a;
  endtask

  task automatic clear_push();
    bus.exp_en   = '0;
    bus.exp_addr = '0;
  endtask

  // Advance one active (falling) edge; update the model and check any pop.
  task automatic tick();
    bit         pop_m;
    bit         push_m;
    bit         dup;
    bit         acc;
    bit         hit_any;
    int         first;
    line_addr_t pa;
    pop_m = (sb.size() != 0) && (bus.out_ready === 1'b1);
    if (pop_m) begin
      n_checks++;
      if (bus.out_addr !== sb[0])
        $display("FAIL pop_order: out_addr=%h expected %h", bus.out_addr, sb[0]);
      else n_pass++;
    end
    push_m = |bus.exp_en;
    pa = '0;
    for (int i = WAYS - 1; i >= 0; i--) if (bus.exp_en[i]) pa = bus.exp_addr[i];
    if ($countones(bus.exp_en) > 1) m_multi = 1'b1;
    first = pop_m ? 1 : 0;
    dup = 1'b0;
    for (int i = first; i < sb.size(); i++) if (sb[i] == pa) dup = 1'b1;
    hit_any = 1'b0;
    for (int i = 0; i < sb.size(); i++) if (sb[i] == bus.lookup_addr) hit_any = 1'b1;
    acc = 1'b0;
    if (bus.flush) sb.delete();
    else begin
      if (pop_m) void'(sb.pop_front());
      if (push_m && !dup) begin
        if (sb.size() < DEPTH) begin sb.push_back(pa); acc = 1'b1; end
        else m_ovf = 1'b1;
      end
    end
    m_hit = bus.lookup_en && (hit_any || (acc && pa == bus.lookup_addr));
    m_af  = (DEPTH - sb.size()) <= AF_MARGIN;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_push();
    bus.flush = 1'b0; bus.out_ready = 1'b0; bus.lookup_en = 1'b0; bus.lookup_addr = '0;
    sb.delete(); m_multi = 0; m_ovf = 0; m_af = 0; m_hit = 0;
    #2;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else n_pass++;
    n_checks++; if (bus.almost_full !== 1'b0) $display("FAIL reset_almost_full got=%b exp=0", bus.almost_full); else n_pass++;
    n_checks++; if ({bus.err_multi, bus.err_ovf, bus.lookup_hit} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.err_multi, bus.err_ovf, bus.lookup_hit}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single_push();
    set_push(2, 37'h0_1234_5678);
    tick();
    clear_push();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_addr !== 37'h0_1234_5678) $display("FAIL single_addr got=%h exp=012345678", bus.out_addr); else n_pass++;
    n_checks++; if (bus.count !== 4'd1) $display("FAIL single_count got=%0d exp=1", bus.count); else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL single_drain_count got=%0d exp=0", bus.count); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    for (int k = 0; k < 8; k++) begin
      set_push(k % 8, line_addr_t'(37'h1_0000_0000 + k));
      tick();
      n_checks++; if (bus.count !== 4'(k + 1)) $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, bus.count, k + 1); else n_pass++;
      n_checks++; if (bus.almost_full !== ((k + 1) >= 6)) $display("FAIL fill_af k=%0d got=%b exp=%b", k, bus.almost_full, (k + 1) >= 6); else n_pass++;
    end
    set_push(1, 37'h1_0000_0008);
    tick();
    n_checks++; if (bus.err_ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", bus.err_ovf); else n_pass++;
    n_checks++; if (bus.count !== 4'd8) $display("FAIL ovf_count got=%0d exp=8", bus.count); else n_pass++;
    set_push(4, 37'h1_0000_0009);
    bus.out_ready = 1'b1;
    tick();
    clear_push();
    n_checks++; if (bus.count !== 4'd8) $display("FAIL full_pushpop_count got=%0d exp=8", bus.count); else n_pass++;
    for (int k = 0; k < 8; k++) tick();
    bus.out_ready = 1'b0;
    n_checks++; if ({bus.out_valid, bus.count, bus.almost_full} !== 6'b0)
      $display("FAIL drain_empty got=%b exp=000000", {bus.out_valid, bus.count, bus.almost_full}); else n_pass++;
    for (int k = 0; k < 3; k++) begin set_push(6, line_addr_t'(37'h0_0BAD_0000 + k)); tick(); end
    clear_push();
    n_checks++; if (bus.count !== 4'd3) $display("FAIL refill_count got=%0d exp=3", bus.count); else n_pass++;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL refill_drain got=%b exp=0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_dedup();
    set_push(1, 37'h0_0000_AAAA); tick();
    set_push(3, 37'h0_0000_AAAA); tick();
    n_checks++; if (bus.count !== 4'd1) $display("FAIL dedup_count got=%0d exp=1", bus.count); else n_pass++;
    set_push(0, 37'h0_0000_AAAA);
    bus.out_ready = 1'b1;
    tick();
    clear_push();
    n_checks++; if (bus.count !== 4'd1) $display("FAIL repush_count got=%0d exp=1", bus.count); else n_pass++;
    n_checks++; if (bus.out_addr !== 37'h0_0000_AAAA) $display("FAIL repush_addr got=%h exp=aaaa", bus.out_addr); else n_pass++;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL dedup_drain got=%0d exp=0", bus.count); else n_pass++;
  endtask

  task automatic test_multi();
    bus.exp_en = 8'h81; bus.exp_addr = '0;
    bus.exp_addr[0] = 37'h0_0000_1111; bus.exp_addr[7] = 37'h0_0000_7777;
    tick();
    clear_push();
    n_checks++; if (bus.err_multi !== 1'b1) $display("FAIL multi_flag got=%b exp=1", bus.err_multi); else n_pass++;
    n_checks++; if (bus.count !== 4'd1 || bus.out_addr !== 37'h0_0000_1111)
      $display("FAIL multi_entry count=%0d addr=%h exp 1/1111", bus.count, bus.out_addr); else n_pass++;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; tick();
    n_checks++; if (bus.err_multi !== 1'b1) $display("FAIL multi_sticky got=%b exp=1", bus.err_multi); else n_pass++;
  endtask

  task automatic test_lookup();
    set_push(2, 37'h0_0000_00A0); tick();
    set_push(5, 37'h0_0000_00B0); tick();
    clear_push();
    bus.lookup_en = 1'b1; bus.lookup_addr = 37'h0_0000_00B0; tick();
    n_checks++; if (bus.lookup_hit !== 1'b1) $display("FAIL lookup_b got=%b exp=1", bus.lookup_hit); else n_pass++;
    bus.lookup_addr = 37'h0_0000_00C0; tick();
    n_checks++; if (bus.lookup_hit !== 1'b0) $display("FAIL lookup_c got=%b exp=0", bus.lookup_hit); else n_pass++;
    bus.lookup_en = 1'b0; bus.lookup_addr = 37'h0_0000_00B0; tick();
    n_checks++; if (bus.lookup_hit !== 1'b0) $display("FAIL lookup_dis got=%b exp=0", bus.lookup_hit); else n_pass++;
    bus.lookup_en = 1'b1; bus.lookup_addr = 37'h0_0000_00D0;
    set_push(6, 37'h0_0000_00D0); tick();
    clear_push();
    n_checks++; if (bus.lookup_hit !== 1'b1) $display("FAIL lookup_samecyc got=%b exp=1", bus.lookup_hit); else n_pass++;
    bus.lookup_addr = 37'h0_0000_00A0; bus.out_ready = 1'b1; tick();
    n_checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_hit !== m_hit)
      $display("FAIL lookup_popping got=%b exp=1", bus.lookup_hit); else n_pass++;
    bus.lookup_en = 1'b0;
    tick(); tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL lookup_drain got=%0d exp=0", bus.count); else n_pass++;
  endtask

  task automatic test_flush_and_reset();
    for (int k = 0; k < 3; k++) begin set_push(k, line_addr_t'(37'h0_0C00_0000 + k)); tick(); end
    n_checks++; if (bus.count !== 4'd3) $display("FAIL preflush_count got=%0d exp=3", bus.count); else n_pass++;
    set_push(3, 37'h0_0C00_00FF); bus.flush = 1'b1; tick();
    bus.flush = 1'b0; clear_push();
    n_checks++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0)
      $display("FAIL flush_empty count=%0d valid=%b exp 0/0", bus.count, bus.out_valid); else n_pass++;
    n_checks++; if ({bus.err_multi, bus.err_ovf} !== {m_multi, m_ovf} || {m_multi, m_ovf} !== 2'b11)
      $display("FAIL flush_keeps_err got=%b exp=11", {bus.err_multi, bus.err_ovf}); else n_pass++;
    for (int k = 0; k < 3; k++) begin set_push(4, line_addr_t'(37'h0_0E00_0000 + k)); tick(); end
    clear_push();
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    bus.lookup_en = 1'b1; bus.lookup_addr = 37'h0_0E00_0002; tick(); bus.lookup_en = 1'b0;
    n_checks++; if (bus.lookup_hit !== 1'b1 || bus.count !== 4'd2)
      $display("FAIL premid_state hit=%b count=%0d exp 1/2", bus.lookup_hit, bus.count); else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    sb.delete(); m_multi = 0; m_ovf = 0;
    n_checks++; if ({bus.out_valid, bus.count, bus.almost_full, bus.lookup_hit} !== 7'b0)
      $display("FAIL async_rst_state got=%b exp=0", {bus.out_valid, bus.count, bus.almost_full, bus.lookup_hit}); else n_pass++;
    n_checks++; if (bus.out_addr !== '0) $display("FAIL async_rst_addr got=%h exp=0", bus.out_addr); else n_pass++;
    n_checks++; if ({bus.err_multi, bus.err_ovf} !== 2'b00) $display("FAIL async_rst_err got=%b exp=00", {bus.err_multi, bus.err_ovf}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    set_push(0, 37'h0_0F00_0000); tick(); clear_push();
    n_checks++; if (bus.count !== 4'd1 || bus.out_addr !== 37'h0_0F00_0000)
      $display("FAIL post_rst_push count=%0d addr=%h exp 1/f000000", bus.count, bus.out_addr); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_dedup();
    test_multi();
    test_lookup();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
